descrambler_8bits: RTL and testbench

Receive-side counterpart of the 8-bit link scrambler. It sits after the 8b/10b decoder and in front of the ordered-set parser. It removes the x^16+x^5+x^4+x^3+1 scrambling from data symbols, re-seeds on COM and holds on SKP exactly as the transmitter does, and runs a COM-based lock state machine. The lock FSM reports whether the descrambler is trustworthy and counts decode errors.

---
 rtl/descrambler_8bits_pkg.sv | 30 +++
 rtl/descrambler_8bits_if.sv | 21 ++
 rtl/descrambler_8bits_lock_fsm.sv | 87 ++++++++
 rtl/descrambler_8bits.sv | 63 ++++++
 tb/tb_descrambler_8bits.sv | 191 +++++++++++++++++++
 5 files changed

// File: rtl/descrambler_8bits_pkg.sv
// Shared definitions for the 8-bit link scrambler and descrambler:
// control symbol codes, LFSR seed, lock-FSM states and the 8-bit-time LFSR update.
package scram_pkg;

  localparam logic [7:0]  K_COM     = 8'hBC;
  localparam logic [7:0]  K_SKP     = 8'h1C;
  localparam logic [15:0] LFSR_INIT = 16'hFFFF;

  typedef enum logic [1:0] {
    HUNT   = 2'd0,
    CHECK  = 2'd1,
    LOCKED = 2'd2
  } rx_lock_state_t;

  // Galois form of x^16+x^5+x^4+x^3+1: bit 15 feeds back into bits 0, 3, 4 and 5.
  function automatic logic [15:0] lfsr_adv8(input logic [15:0] lfsr);
    logic [15:0] s;
    logic        fb;
    s = lfsr;
    for (int i = 0; i < 8; i++) begin
      fb   = s[15];
      s    = {s[14:0], fb};
      s[3] = s[3] ^ fb;
      s[4] = s[4] ^ fb;
      s[5] = s[5] ^ fb;
    end
    return s;
  endfunction

endpackage

// File: rtl/descrambler_8bits_if.sv
// Symbol stream into and out of the descrambler.
// valid_in/valid_out are one-cycle strobes with no ready: the receiver must take every strobed symbol.
interface descrambler_8bits_if;
  logic [7:0] data_in;
  logic       k_in;
  logic       valid_in;
  logic       decode_err_in;
  logic [7:0] data_out;
  logic       k_out;
  logic       valid_out;

  modport master (
    output data_in, k_in, valid_in, decode_err_in,
    input  data_out, k_out, valid_out
  );

  modport slave (
    input  data_in, k_in, valid_in, decode_err_in,
    output data_out, k_out, valid_out
  );
endinterface

// File: rtl/descrambler_8bits_lock_fsm.sv
// COM-based lock state machine with COM gap timer, consecutive-error run
// counter and saturating decode-error counter.
module descram_lock_fsm
  import scram_pkg::*;
#(
  parameter int LOCK_TIMEOUT = 2048,
  parameter int ERR_THRESH   = 4
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           sym_valid,
  input  logic           sym_com,
  input  logic           sym_err,
  output logic           locked,
  output logic [7:0]     err_count,
  output rx_lock_state_t state
);

  localparam int GW = $clog2(LOCK_TIMEOUT + 1);
  localparam int EW = $clog2(ERR_THRESH + 1);
  localparam logic [GW-1:0] GAP_MAX = GW'(LOCK_TIMEOUT);
  localparam logic [EW-1:0] RUN_MAX = EW'(ERR_THRESH);

  logic [GW-1:0] gap_cnt, gap_nxt;
  logic [EW-1:0] err_run, run_nxt;
  logic          timeout_hit, thresh_hit;

  always_comb begin
    gap_nxt = gap_cnt;
    if (sym_com)
      gap_nxt = '0;
    else if (gap_cnt != GAP_MAX)
      gap_nxt = gap_cnt + 1'b1;

    run_nxt = err_run;
    if (sym_err) begin
      if (err_run != RUN_MAX)
        run_nxt = err_run + 1'b1;
    end else if (sym_valid) begin
      run_nxt = '0;
    end

    // A clean COM zeroes gap_nxt, so it always beats a coincident timeout.
    timeout_hit = sym_valid && (gap_nxt == GAP_MAX);
    thresh_hit  = sym_err && (run_nxt == RUN_MAX);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= HUNT;
      locked    <= 1'b0;
      gap_cnt   <= '0;
      err_run   <= '0;
      err_count <= 8'd0;
    end else if (sym_valid) begin
      gap_cnt <= gap_nxt;
      err_run <= run_nxt;
      if (sym_err && err_count != 8'hFF)
        err_count <= err_count + 8'd1;
      case (state)
        HUNT: begin
          if (sym_com)
            state <= CHECK;
        end
        CHECK: begin
          if (sym_com) begin
            state  <= LOCKED;
            locked <= 1'b1;
          end else if (sym_err || timeout_hit) begin
            state <= HUNT;
          end
        end
        LOCKED: begin
          if (timeout_hit || thresh_hit) begin
            state  <= HUNT;
            locked <= 1'b0;
          end
        end
        default: begin
          state  <= HUNT;
          locked <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: rtl/descrambler_8bits.sv
// Receive descrambler: undoes the x^16+x^5+x^4+x^3+1 scrambling, re-seeds on COM,
// holds on SKP, and reports COM-based lock through descram_lock_fsm.
module descrambler_8bits
  import scram_pkg::*;
#(
  parameter int LOCK_TIMEOUT = 2048,
  parameter int ERR_THRESH   = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  descrambler_8bits_if.slave   sym,
  input  logic                 disab_scram,
  output logic                 locked,
  output logic [7:0]           err_count,
  output rx_lock_state_t       lock_state
);

  logic [15:0] lfsr;
  logic [7:0]  key;
  logic        is_com, is_skp;

  assign is_com = sym.k_in && (sym.data_in == K_COM) && !sym.decode_err_in;
  assign is_skp = sym.k_in && (sym.data_in == K_SKP) && !sym.decode_err_in;

  // data bit i is XORed with lfsr[15-i], i.e. the bit-reversed top byte.
  always_comb begin
    key = {lfsr[8], lfsr[9], lfsr[10], lfsr[11], lfsr[12], lfsr[13], lfsr[14], lfsr[15]};
    if (sym.k_in || disab_scram)
      key = 8'h00;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      lfsr          <= LFSR_INIT;
      sym.data_out  <= 8'h00;
      sym.k_out     <= 1'b0;
      sym.valid_out <= 1'b0;
    end else begin
      sym.valid_out <= sym.valid_in;
      if (sym.valid_in) begin
        sym.data_out <= sym.data_in ^ key;
        sym.k_out    <= sym.k_in;
        if (!(disab_scram || is_skp))
          lfsr <= is_com ? LFSR_INIT : lfsr_adv8(lfsr);
      end
    end
  end

  descram_lock_fsm #(
    .LOCK_TIMEOUT (LOCK_TIMEOUT),
    .ERR_THRESH   (ERR_THRESH)
  ) u_lock_fsm (
    .clk       (clk),
    .rst       (rst),
    .sym_valid (sym.valid_in),
    .sym_com   (sym.valid_in && is_com),
    .sym_err   (sym.valid_in && sym.decode_err_in),
    .locked    (locked),
    .err_count (err_count),
    .state     (lock_state)
  );

endmodule

// File: tb/tb_descrambler_8bits.sv
// Directed bench for descrambler_8bits: vector table for the data path and
// hand-written sequences for lock timeout, error runs, reset and saturation.
module tb_descrambler_8bits;
  import scram_pkg::*;

  localparam int TO = 2048;

  logic           clk;
  logic           rst;
  logic           disab_scram;
  logic           locked;
  logic [7:0]     err_count;
  rx_lock_state_t lock_state;

  descrambler_8bits_if sym_if ();

  descrambler_8bits #(.LOCK_TIMEOUT(TO), .ERR_THRESH(4)) dut (
    .clk         (clk),
    .rst         (rst),
    .sym         (sym_if),
    .disab_scram (disab_scram),
    .locked      (locked),
    .err_count   (err_count),
    .lock_state  (lock_state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_vec  = 0;
  int n_miss = 0;

  typedef struct {
    logic       r;
    logic [7:0] d;
    logic       k, v, e, ds;
    logic [7:0] xd;
    logic       xk, xv, xl;
    logic [1:0] xs;
    logic [7:0] xec;
  } vec_t;

  vec_t tbl [23];

  function automatic vec_t mk(input logic r, input logic [7:0] d, input logic k, input logic v,
                              input logic e, input logic ds, input logic [7:0] xd, input logic xk,
                              input logic xv, input logic xl, input logic [1:0] xs,
                              input logic [7:0] xec);
    vec_t t;
    t.r = r; t.d = d; t.k = k; t.v = v; t.e = e; t.ds = ds;
    t.xd = xd; t.xk = xk; t.xv = xv; t.xl = xl; t.xs = xs; t.xec = xec;
    return t;
  endfunction

  task automatic chk(input string name, input int idx, input logic [15:0] got, input logic [15:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s[%0d]: got %h, want %h", name, idx, got, exp);
    end
  endtask

  task automatic step(input logic r, input logic [7:0] d, input logic k, input logic v,
                      input logic e, input logic ds);
    @(negedge clk);
    rst                  = r;
    sym_if.data_in       = d;
    sym_if.k_in          = k;
    sym_if.valid_in      = v;
    sym_if.decode_err_in = e;
    disab_scram          = ds;
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [7:0] d, input logic k, input logic e);
    step(1'b0, d, k, 1'b1, e, 1'b0);
  endtask

  task automatic reset_com_com();
    step(1'b1, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
    send(K_COM, 1'b1, 1'b0);
    send(K_COM, 1'b1, 1'b0);
  endtask

  initial begin
    rst = 1'b1; disab_scram = 1'b0;
    sym_if.data_in = 8'h00; sym_if.k_in = 1'b0;
    sym_if.valid_in = 1'b0; sym_if.decode_err_in = 1'b0;

    //            r  d      k  v  e  ds  xd     xk xv xl xs  xec
    tbl[0]  = mk(1, 8'h00, 0, 0, 0, 0, 8'h00, 0, 0, 0, 0, 8'd0);
    tbl[1]  = mk(0, 8'hBC, 1, 1, 0, 0, 8'hBC, 1, 1, 0, 1, 8'd0);
    tbl[2]  = mk(0, 8'hFF, 0, 1, 0, 0, 8'h00, 0, 1, 0, 1, 8'd0);
    tbl[3]  = mk(0, 8'h17, 0, 1, 0, 0, 8'h00, 0, 1, 0, 1, 8'd0);
    tbl[4]  = mk(0, 8'hC0, 0, 1, 0, 0, 8'h00, 0, 1, 0, 1, 8'd0);
    tbl[5]  = mk(0, 8'hBC, 1, 1, 0, 0, 8'hBC, 1, 1, 1, 2, 8'd0);
    tbl[6]  = mk(0, 8'hFF, 0, 1, 0, 0, 8'h00, 0, 1, 1, 2, 8'd0);
    tbl[7]  = mk(0, 8'h1C, 1, 1, 0, 0, 8'h1C, 1, 1, 1, 2, 8'd0);
    tbl[8]  = mk(0, 8'h17, 0, 1, 0, 0, 8'h00, 0, 1, 1, 2, 8'd0);
    tbl[9]  = mk(0, 8'h55, 1, 0, 0, 0, 8'h00, 0, 0, 1, 2, 8'd0);
    tbl[10] = mk(0, 8'hC0, 0, 1, 0, 0, 8'h00, 0, 1, 1, 2, 8'd0);
    tbl[11] = mk(1, 8'hBC, 1, 1, 0, 0, 8'h00, 0, 0, 0, 0, 8'd0);
    tbl[12] = mk(0, 8'hBC, 1, 1, 0, 0, 8'hBC, 1, 1, 0, 1, 8'd0);
    tbl[13] = mk(0, 8'hFF, 0, 1, 0, 0, 8'h00, 0, 1, 0, 1, 8'd0);
    tbl[14] = mk(1, 8'h00, 0, 0, 0, 0, 8'h00, 0, 0, 0, 0, 8'd0);
    tbl[15] = mk(0, 8'hBC, 1, 1, 0, 1, 8'hBC, 1, 1, 0, 1, 8'd0);
    tbl[16] = mk(0, 8'hFF, 0, 1, 0, 1, 8'hFF, 0, 1, 0, 1, 8'd0);
    tbl[17] = mk(0, 8'h17, 0, 1, 0, 1, 8'h17, 0, 1, 0, 1, 8'd0);
    tbl[18] = mk(0, 8'hFF, 0, 1, 0, 0, 8'h00, 0, 1, 0, 1, 8'd0);
    tbl[19] = mk(0, 8'h17, 0, 1, 0, 0, 8'h00, 0, 1, 0, 1, 8'd0);
    tbl[20] = mk(0, 8'h00, 0, 1, 1, 0, 8'hC0, 0, 1, 0, 0, 8'd1);
    tbl[21] = mk(0, 8'hBC, 1, 1, 1, 0, 8'hBC, 1, 1, 0, 0, 8'd2);
    tbl[22] = mk(0, 8'hBC, 1, 1, 0, 0, 8'hBC, 1, 1, 0, 1, 8'd2);

    for (int i = 0; i < 23; i++) begin
      step(tbl[i].r, tbl[i].d, tbl[i].k, tbl[i].v, tbl[i].e, tbl[i].ds);
      chk("data_out",  i, sym_if.data_out,  tbl[i].xd);
      chk("k_out",     i, sym_if.k_out,     tbl[i].xk);
      chk("valid_out", i, sym_if.valid_out, tbl[i].xv);
      chk("locked",    i, locked,           tbl[i].xl);
      chk("state",     i, lock_state,       tbl[i].xs);
      chk("err_count", i, err_count,        tbl[i].xec);
    end

    // COM, 10 data, COM locks; then a COM-free run of TO symbols drops lock on the last.
    step(1'b1, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
    send(K_COM, 1'b1, 1'b0);
    for (int i = 0; i < 10; i++) send(8'h00, 1'b0, 1'b0);
    chk("pre_lock", 0, locked, 1'b0);
    send(K_COM, 1'b1, 1'b0);
    chk("lock_rise", 0, locked, 1'b1);
    for (int i = 0; i < TO - 1; i++) send(8'h00, 1'b0, 1'b0);
    chk("lock_hold_to_m1", 0, locked, 1'b1);
    send(8'h00, 1'b0, 1'b0);
    chk("timeout_drop", 0, locked, 1'b0);
    chk("timeout_state", 0, lock_state, HUNT);

    // COM arriving on the would-be timeout symbol keeps lock.
    reset_com_com();
    for (int i = 0; i < TO - 1; i++) send(8'h00, 1'b0, 1'b0);
    send(K_COM, 1'b1, 1'b0);
    chk("com_wins", 0, locked, 1'b1);
    send(8'h00, 1'b0, 1'b0);
    chk("com_wins_after", 0, locked, 1'b1);

    // 3 errors, 1 clean, 4 errors: only the 4th consecutive error drops lock.
    reset_com_com();
    for (int i = 0; i < 3; i++) send(8'h00, 1'b0, 1'b1);
    chk("burst1", 0, locked, 1'b1);
    send(8'h00, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) send(8'h00, 1'b0, 1'b1);
    chk("burst2_3", 0, locked, 1'b1);
    send(8'h00, 1'b0, 1'b1);
    chk("burst2_4", 0, locked, 1'b0);
    chk("err_count7", 0, err_count, 8'd7);

    // Reset pulsed mid-stream while locked.
    send(K_COM, 1'b1, 1'b0);
    send(K_COM, 1'b1, 1'b0);
    chk("relock", 0, locked, 1'b1);
    step(1'b1, K_COM, 1'b1, 1'b1, 1'b0, 1'b0);
    chk("rst_locked", 0, locked, 1'b0);
    chk("rst_valid", 0, sym_if.valid_out, 1'b0);
    chk("rst_errcnt", 0, err_count, 8'd0);
    send(K_COM, 1'b1, 1'b0);
    chk("post_rst_com", 0, sym_if.data_out, 8'hBC);
    send(8'hFF, 1'b0, 1'b0);
    chk("post_rst_ff", 0, sym_if.data_out, 8'h00);

    // 4th error lands on the timeout symbol: single drop to HUNT.
    reset_com_com();
    for (int i = 0; i < TO - 4; i++) send(8'h00, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) send(8'h00, 1'b0, 1'b1);
    chk("simul_pre", 0, locked, 1'b1);
    send(8'h00, 1'b0, 1'b1);
    chk("simul_locked", 0, locked, 1'b0);
    chk("simul_state", 0, lock_state, HUNT);
    send(8'h00, 1'b0, 1'b0);
    chk("simul_after", 0, lock_state, HUNT);

    // err_count saturates at 255.
    step(1'b1, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 260; i++) send(8'h00, 1'b0, 1'b1);
    chk("err_sat", 0, err_count, 8'hFF);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
